// File: rtl/re_k_calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : re_k_calc_ctrl
// Description : Sequencing controller for the RE k-calc datapath. It runs the
//               handshake, drives the datapath enable, tracks in-flight
//               valid/last and frames each run. The optional statistics
//               counters are built when RE_K_CTRL_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module re_k_calc_ctrl #(
    parameter int LATENCY   = 9,
    parameter int CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 dp_en,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_lst;
    logic               w_stall;
    logic               w_accept;
    logic               w_xfer;

    // Output side reads the tail of the shadow pipeline; a stall freezes all of it.
    assign out_valid  = r_vld[LATENCY-1];
    assign out_last   = r_lst[LATENCY-1];
    assign w_stall    = out_valid & ~out_ready;
    assign dp_en      = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) & ~w_stall;
    assign in_ready   = (r_state == ST_RUN) & dp_en;
    assign w_accept   = in_valid & in_ready;
    assign w_xfer     = out_valid & out_ready;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start)                 w_state_nxt = ST_RUN;
                ST_RUN:   if (w_accept && in_last)   w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (w_xfer && out_last)    w_state_nxt = ST_DONE;
                ST_DONE:                             w_state_nxt = ST_IDLE;
                default:                             w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (abort) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (dp_en) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
            r_vld[0] <= w_accept;
            r_lst[0] <= w_accept & in_last;
        end
    end

`ifdef RE_K_CTRL_STATS_EN
    logic [CNT_WIDTH-1:0] r_sample_count;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic                 w_cnt_clr;

    assign w_cnt_clr = abort | ((r_state == ST_IDLE) & start);

    // Saturating counters; values persist after DONE until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_count <= '0;
            r_stall_count  <= '0;
        end else if (w_cnt_clr) begin
            r_sample_count <= '0;
            r_stall_count  <= '0;
        end else begin
            if (w_accept && !(&r_sample_count)) begin
                r_sample_count <= r_sample_count + CNT_WIDTH'(1);
            end
            if (w_stall && !(&r_stall_count)) begin
                r_stall_count <= r_stall_count + CNT_WIDTH'(1);
            end
        end
    end

    assign sample_count = r_sample_count;
    assign stall_count  = r_stall_count;
`else
    assign sample_count = '0;
    assign stall_count  = '0;
`endif

endmodule
`default_nettype wire
